// File: rtl/servo_pkg.sv
// Shared servo types and default frame timing.
// Effort width is shared with the P/I/D controller datapath.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_e;

  localparam int N_DEF         = 19;
  localparam int PERIOD_DEF    = 1000000;
  localparam int CENTER_DEF    = 75000;
  localparam int MIN_PULSE_DEF = 50000;
  localparam int MAX_PULSE_DEF = 100000;

endpackage

// File: rtl/servo_duty_clamp.sv
// Effort to pulse width: sign-extend, add CENTER, clamp to MIN/MAX.
// SERVO_PWM_SLEW_EN adds a per-frame step limit around the current duty.
module servo_duty_clamp
  import servo_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int CNT_W     = 20,
  parameter int CENTER    = CENTER_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int MAX_PULSE = MAX_PULSE_DEF
`ifdef SERVO_PWM_SLEW_EN
  ,
  parameter int MAX_STEP  = 2500
`endif
) (
  input  logic signed [N-1:0]     u_i,
`ifdef SERVO_PWM_SLEW_EN
  input  logic        [CNT_W-1:0] cur_i,
`endif
  output logic        [CNT_W-1:0] duty_o,
  output logic                    sat_o
);

  localparam int W = ((N > CNT_W) ? N : CNT_W) + 2;

  localparam logic signed [W-1:0] CEN_S = W'(CENTER);
  localparam logic signed [W-1:0] MIN_S = W'(MIN_PULSE);
  localparam logic signed [W-1:0] MAX_S = W'(MAX_PULSE);

  logic signed [W-1:0] sum;
  logic signed [W-1:0] tgt;

  always_comb begin
    sum   = CEN_S + W'(u_i);
    tgt   = sum;
    sat_o = 1'b0;
    if (sum < MIN_S) begin
      tgt   = MIN_S;
      sat_o = 1'b1;
    end else if (sum > MAX_S) begin
      tgt   = MAX_S;
      sat_o = 1'b1;
    end
  end

`ifdef SERVO_PWM_SLEW_EN
  localparam logic signed [W-1:0] STEP_S = W'(MAX_STEP);

  logic signed [W-1:0] cur;
  logic signed [W-1:0] lo;
  logic signed [W-1:0] hi;
  logic signed [W-1:0] lim;

  // Limit applies after the clamp, so sat_o never sees it.
  always_comb begin
    cur = W'(cur_i);
    lo  = cur - STEP_S;
    hi  = cur + STEP_S;
    lim = tgt;
    if (tgt > hi) begin
      lim = hi;
    end else if (tgt < lo) begin
      lim = lo;
    end
    duty_o = CNT_W'(lim);
  end
`else
  always_comb begin
    duty_o = CNT_W'(tgt);
  end
`endif

endmodule

// File: rtl/servo_pwm_gen.sv
// Fixed-period servo PWM with frame-boundary duty update and frame tick.
// Define SERVO_PWM_SLEW_EN to rate-limit duty changes per frame.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int CNT_W     = 20,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int CENTER    = CENTER_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int MAX_PULSE = MAX_PULSE_DEF,
  parameter int MAX_STEP  = 2500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [N-1:0]     u_k,
  input  logic                    u_valid,
  output logic                    pwm_out,
  output logic                    sample_tick,
  output logic                    sat_flag,
  output logic        [CNT_W-1:0] duty_act
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CEN  = CNT_W'(CENTER);

  state_e state_q, state_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    duty_q, duty_d, duty_new;
  logic signed [N-1:0] u_pend_q, u_sel;
  logic                sat_q, sat_d, sat_new;
  logic                pwm_q, pwm_d;
  logic                tick_q, tick_d;
  logic                last, load;

  assign last  = (cnt_q == LAST);
  // A strobe on the boundary cycle bypasses the pending register.
  assign u_sel = u_valid ? u_k : u_pend_q;

  servo_duty_clamp #(
    .N         (N),
    .CNT_W     (CNT_W),
    .CENTER    (CENTER),
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE)
`ifdef SERVO_PWM_SLEW_EN
    ,
    .MAX_STEP  (MAX_STEP)
`endif
  ) u_clamp (
    .u_i    (u_sel),
`ifdef SERVO_PWM_SLEW_EN
    .cur_i  (duty_q),
`endif
    .duty_o (duty_new),
    .sat_o  (sat_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN:  if (!en) state_d = STOP;
      STOP: begin
        if (en) begin
          state_d = RUN;
        end else if (last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = (state_q == IDLE || last) ? '0 : cnt_q + CNT_W'(1);
    load   = last && (state_q == RUN || state_d == RUN);
    duty_d = load ? duty_new : duty_q;
    sat_d  = load ? sat_new : sat_q;
    tick_d = (state_d == RUN) && (cnt_d == '0);
    pwm_d  = (state_d != IDLE) && (cnt_d < duty_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      u_pend_q <= '0;
      duty_q   <= CEN;
      sat_q    <= 1'b0;
      pwm_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      sat_q    <= sat_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
      if (u_valid) u_pend_q <= u_k;
    end
  end

  assign pwm_out     = pwm_q;
  assign sample_tick = tick_q;
  assign sat_flag    = sat_q;
  assign duty_act    = duty_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Randomized frame-level bench for servo_pwm_gen against a frame model.
// Build with SERVO_PWM_SLEW_EN to exercise the slew-limited variant.
module tb_servo_pwm_gen;

  localparam int N      = 19;
  localparam int CNT_W  = 20;
  localparam int PERIOD = 100;
  localparam int CENTER = 50;
  localparam int MINP   = 10;
  localparam int MAXP   = 90;
  localparam int STEP   = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic signed [N-1:0]     u_k;
  logic                    u_valid;
  logic                    pwm_out;
  logic                    sample_tick;
  logic                    sat_flag;
  logic        [CNT_W-1:0] duty_act;

  int n_chk  = 0;
  int n_pass = 0;

  int m_pend;
  int m_duty;
  int m_sat;

  servo_pwm_gen #(
    .N         (N),
    .CNT_W     (CNT_W),
    .PERIOD    (PERIOD),
    .CENTER    (CENTER),
    .MIN_PULSE (MINP),
    .MAX_PULSE (MAXP),
    .MAX_STEP  (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .u_k         (u_k),
    .u_valid     (u_valid),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .sat_flag    (sat_flag),
    .duty_act    (duty_act)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int val);
    u_valid = v;
    u_k     = N'(val);
    if (v) m_pend = val;
  endtask

  function automatic int rand_u();
    int r;
    case ($urandom_range(0, 3))
      0: r = int'($urandom_range(0, 120)) - 60;
      1: r = int'($urandom_range(0, 400)) - 200;
      2: r = $urandom_range(0, 1) ? 262143 : -262144;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Frame boundary: pulse = CENTER + effort, clamped, optionally slewed.
  task automatic model_load();
    int tgt;
    tgt   = CENTER + m_pend;
    m_sat = 0;
    if (tgt < MINP) begin
      tgt   = MINP;
      m_sat = 1;
    end else if (tgt > MAXP) begin
      tgt   = MAXP;
      m_sat = 1;
    end
`ifdef SERVO_PWM_SLEW_EN
    if (tgt > m_duty + STEP) tgt = m_duty + STEP;
    else if (tgt < m_duty - STEP) tgt = m_duty - STEP;
`endif
    m_duty = tgt;
  endtask

  task automatic idle_cycles(input int n, input bit reen);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_pwm", pwm_out, 0);
      chk("idle_tick", sample_tick, 0);
      chk("idle_duty", duty_act, m_duty);
      chk("idle_sat", sat_flag, m_sat);
      drive($urandom_range(0, 3) == 0, rand_u());
      en = reen && (i == n - 1);
    end
  endtask

  // One full frame; p<0 means no strobe, off<0 means en stays high.
  task automatic frame(input int p1, input int v1, input int p2,
                       input int v2, input int off);
    for (int pos = 0; pos < PERIOD; pos++) begin
      step();
      chk("tick", sample_tick, int'(pos == 0));
      chk("pwm", pwm_out, int'(pos < m_duty));
      if (pos == 0) begin
        chk("duty_act", duty_act, m_duty);
        chk("sat_flag", sat_flag, m_sat);
      end
      if (pos == p1) drive(1'b1, v1);
      else if (pos == p2) drive(1'b1, v2);
      else drive(1'b0, int'($urandom));
      en = !(off >= 0 && pos >= off);
    end
    if (off < 0) model_load();
  endtask

  initial begin
    int p1, p2, v1, v2, off;
    rst     = 1'b1;
    en      = 1'b1;
    u_valid = 1'b0;
    u_k     = '0;
    m_pend  = 0;
    m_duty  = CENTER;
    m_sat   = 0;

    repeat (3) step();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_duty", duty_act, CENTER);

    rst = 1'b0;
    en  = 1'b0;
    idle_cycles(300, 1'b1);

    frame(40, 0, -1, 0, -1);
    frame(40, 25, -1, 0, -1);
    frame(40, -19, -1, 0, -1);
    frame(10, 200, -1, 0, -1);
    frame(10, -262144, -1, 0, -1);
    frame(10, 0, -1, 0, -1);
    frame(99, 10, -1, 0, -1);
    frame(0, 33, 50, 0, -1);
    frame(-1, 0, -1, 0, 20);
    idle_cycles(150, 1'b1);

    frame(30, 25, -1, 0, -1);
    repeat (6) frame(-1, 0, -1, 0, -1);

    for (int k = 0; k < 30; k++) begin
      p1  = $urandom_range(0, 2) == 0 ? -1 : int'($urandom_range(0, PERIOD - 1));
      p2  = $urandom_range(0, 1) == 0 ? -1 : int'($urandom_range(0, PERIOD - 1));
      if ($urandom_range(0, 4) == 0) p2 = PERIOD - 1;
      v1  = rand_u();
      v2  = rand_u();
      off = $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 90)) : -1;
      frame(p1, v1, p2, v2, off);
      if (off >= 0) idle_cycles(int'($urandom_range(1, 40)), 1'b1);
    end

    repeat (30) begin
      step();
      drive(1'b0, 0);
    end
    rst = 1'b1;
    step();
    m_pend = 0;
    m_duty = CENTER;
    m_sat  = 0;
    chk("midrst_pwm", pwm_out, 0);
    chk("midrst_tick", sample_tick, 0);
    chk("midrst_duty", duty_act, CENTER);
    chk("midrst_sat", sat_flag, 0);
    rst = 1'b0;
    en  = 1'b0;
    idle_cycles(20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
